// File: rtl/hacd_pkg.sv
// hacd_pkg: types shared between the CPU request gate and the hawk control unit.
//   cpu_reqpkt_t        - lookup request {valid, hppa} sent to the control unit
//   hawk_cpu_ovrd_pkt_t - grant {allow_access, ppa} returned by the control unit
//   chan_state_t        - per-channel gate state (read channel never uses ST_DATA)
//   PG_OFF_W            - page offset width; the host page number is addr >> PG_OFF_W
package hacd_pkg;

  localparam int PG_OFF_W = 12;
  localparam int HPPA_W   = 52;
  localparam int PPA_W    = 52;

  typedef struct packed {
    logic              valid;
    logic [HPPA_W-1:0] hppa;
  } cpu_reqpkt_t;

  typedef struct packed {
    logic             allow_access;
    logic [PPA_W-1:0] ppa;
  } hawk_cpu_ovrd_pkt_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DATA  = 2'd3
  } chan_state_t;

endpackage

// File: rtl/hawk_req_gate_chan.sv
// hawk_req_gate_chan: one address channel of the CPU request gate.
// Accepts a single CPU address, asks the control unit for a translation,
// waits for the grant, then issues the translated address downstream.
// With HAS_WDATA set, write data is only passed after the translated AW
// has handshaken, until the beat carrying wlast.
// Ports:
//   clk, srst                 clock, synchronous active-high reset
//   init_done                 gates acceptance of new addresses
//   cpu_valid/ready/addr/id/len  upstream address channel
//   mem_valid/ready/addr/id/len  downstream (translated) address channel
//   cpu_w_valid/ready/last, mem_w_valid/ready  write-data gate (HAS_WDATA only)
//   reqpkt / ovrd             lookup request to / grant from the control unit
//   tmo_err                   sticky flag: waited too long for a grant
module hawk_req_gate_chan
  import hacd_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int ID_W      = 5,
  parameter int PG_OFF_W  = hacd_pkg::PG_OFF_W,
  parameter int TMO_W     = 16,
  parameter bit HAS_WDATA = 1'b0
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               init_done,
  input  logic               cpu_valid,
  output logic               cpu_ready,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [ID_W-1:0]    cpu_id,
  input  logic [7:0]         cpu_len,
  output logic               mem_valid,
  input  logic               mem_ready,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [ID_W-1:0]    mem_id,
  output logic [7:0]         mem_len,
  input  logic               cpu_w_valid,
  output logic               cpu_w_ready,
  input  logic               cpu_w_last,
  output logic               mem_w_valid,
  input  logic               mem_w_ready,
  output cpu_reqpkt_t        reqpkt,
  input  hawk_cpu_ovrd_pkt_t ovrd,
  output logic               tmo_err
);

  localparam int PN_W = ADDR_W - PG_OFF_W;
  localparam logic [TMO_W-1:0] CNT_MAX = {TMO_W{1'b1}};
  // The flag is set on the edge where the counter becomes all-ones.
  localparam logic [TMO_W-1:0] CNT_PRE = {{(TMO_W-1){1'b1}}, 1'b0};

  chan_state_t        state_reg, state_next;
  logic [ADDR_W-1:0]  addr_reg;
  logic [ID_W-1:0]    id_reg;
  logic [7:0]         len_reg;
  logic [PPA_W-1:0]   ppa_reg;
  logic [TMO_W-1:0]   cnt_reg;
  logic               tmo_reg;
  logic               accept;
  logic               w_phase;
  logic [PN_W-1:0]    ppa_fit;

  // Read instance folds this to 0, removing the data gate entirely.
  assign w_phase = HAS_WDATA && (state_reg == ST_DATA);

  always_comb begin
    state_next   = state_reg;
    cpu_ready    = 1'b0;
    mem_valid    = 1'b0;
    cpu_w_ready  = 1'b0;
    mem_w_valid  = 1'b0;
    reqpkt       = '0;
    accept       = 1'b0;

    // Outputs are forced low while reset is asserted so that no handshake
    // can complete in the reset cycle itself.
    if (!srst) begin
      cpu_ready    = init_done && (state_reg == ST_IDLE);
      mem_valid    = (state_reg == ST_ISSUE);
      // Drop valid in the grant cycle so the control unit never sees a
      // second request for the same transaction.
      reqpkt.valid = (state_reg == ST_REQ) && !ovrd.allow_access;
      if (w_phase) begin
        mem_w_valid = cpu_w_valid;
        cpu_w_ready = mem_w_ready;
      end
    end
    reqpkt.hppa = HPPA_W'(addr_reg[ADDR_W-1:PG_OFF_W]);
    accept      = cpu_valid && cpu_ready;

    case (state_reg)
      ST_IDLE:  if (accept) state_next = ST_REQ;
      ST_REQ:   if (ovrd.allow_access) state_next = ST_ISSUE;
      ST_ISSUE: if (mem_valid && mem_ready) state_next = HAS_WDATA ? ST_DATA : ST_IDLE;
      ST_DATA:  if (cpu_w_valid && mem_w_ready && cpu_w_last) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg <= ST_IDLE;
      addr_reg  <= '0;
      id_reg    <= '0;
      len_reg   <= '0;
      ppa_reg   <= '0;
      cnt_reg   <= '0;
      tmo_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        addr_reg <= cpu_addr;
        id_reg   <= cpu_id;
        len_reg  <= cpu_len;
      end
      if (state_reg == ST_REQ && ovrd.allow_access) begin
        ppa_reg <= ovrd.ppa;
      end
      // Wait counter: runs only in REQ, saturates, never aborts the wait.
      if (state_reg == ST_REQ) begin
        if (cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + 1'b1;
        if (cnt_reg == CNT_PRE) tmo_reg <= 1'b1;
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  // Wider ppa is truncated, narrower ppa zero-extended.
  assign ppa_fit  = PN_W'(ppa_reg);
  assign mem_addr = {ppa_fit, addr_reg[PG_OFF_W-1:0]};
  assign mem_id   = id_reg;
  assign mem_len  = len_reg;
  assign tmo_err  = tmo_reg;

endmodule

// File: rtl/hawk_cpu_req_gate.sv
// hawk_cpu_req_gate: holds CPU AR/AW transactions until the hawk control unit
// grants them, replaces the host page number with the granted ppa, and keeps
// write data behind its translated AW.
// Ports:
//   clk_i, rst_i, init_done         clock, sync active-high reset, init complete
//   cpu_ar_*, cpu_aw_*              CPU address channels (valid/ready/addr/id/len)
//   cpu_w_valid/ready/last          CPU write-data control
//   mem_ar_*, mem_aw_*              translated address channels to memory
//   mem_w_valid/ready               gated write-data control
//   cpu_rd_reqpkt, cpu_wr_reqpkt    lookup requests to the control unit
//   hawk_cpu_ovrd_rdpkt/_wrpkt      grants from the control unit
//   tmo_err                         sticky {wr, rd} grant-timeout flags
module hawk_cpu_req_gate
  import hacd_pkg::*;
#(
  parameter int ADDR_W   = 64,
  parameter int ID_W     = 5,
  parameter int PG_OFF_W = hacd_pkg::PG_OFF_W,
  parameter int TMO_W    = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               init_done,
  input  logic               cpu_ar_valid,
  output logic               cpu_ar_ready,
  input  logic [ADDR_W-1:0]  cpu_ar_addr,
  input  logic [ID_W-1:0]    cpu_ar_id,
  input  logic [7:0]         cpu_ar_len,
  input  logic               cpu_aw_valid,
  output logic               cpu_aw_ready,
  input  logic [ADDR_W-1:0]  cpu_aw_addr,
  input  logic [ID_W-1:0]    cpu_aw_id,
  input  logic [7:0]         cpu_aw_len,
  input  logic               cpu_w_valid,
  output logic               cpu_w_ready,
  input  logic               cpu_w_last,
  output logic               mem_ar_valid,
  input  logic               mem_ar_ready,
  output logic [ADDR_W-1:0]  mem_ar_addr,
  output logic [ID_W-1:0]    mem_ar_id,
  output logic [7:0]         mem_ar_len,
  output logic               mem_aw_valid,
  input  logic               mem_aw_ready,
  output logic [ADDR_W-1:0]  mem_aw_addr,
  output logic [ID_W-1:0]    mem_aw_id,
  output logic [7:0]         mem_aw_len,
  output logic               mem_w_valid,
  input  logic               mem_w_ready,
  output cpu_reqpkt_t        cpu_rd_reqpkt,
  output cpu_reqpkt_t        cpu_wr_reqpkt,
  input  hawk_cpu_ovrd_pkt_t hawk_cpu_ovrd_rdpkt,
  input  hawk_cpu_ovrd_pkt_t hawk_cpu_ovrd_wrpkt,
  output logic [1:0]         tmo_err
);

  // Channel index 0 = read, 1 = write (matches the tmo_err bit order).
  logic [1:0]         cpu_valid_a, cpu_ready_a, mem_valid_a, mem_ready_a;
  logic [1:0]         w_ready_a, w_valid_a, tmo_a;
  logic [ADDR_W-1:0]  cpu_addr_a [2];
  logic [ADDR_W-1:0]  mem_addr_a [2];
  logic [ID_W-1:0]    cpu_id_a   [2];
  logic [ID_W-1:0]    mem_id_a   [2];
  logic [7:0]         cpu_len_a  [2];
  logic [7:0]         mem_len_a  [2];
  cpu_reqpkt_t        reqpkt_a   [2];
  hawk_cpu_ovrd_pkt_t ovrd_a     [2];

  assign cpu_valid_a   = {cpu_aw_valid, cpu_ar_valid};
  assign mem_ready_a   = {mem_aw_ready, mem_ar_ready};
  assign cpu_addr_a[0] = cpu_ar_addr;
  assign cpu_addr_a[1] = cpu_aw_addr;
  assign cpu_id_a[0]   = cpu_ar_id;
  assign cpu_id_a[1]   = cpu_aw_id;
  assign cpu_len_a[0]  = cpu_ar_len;
  assign cpu_len_a[1]  = cpu_aw_len;
  assign ovrd_a[0]     = hawk_cpu_ovrd_rdpkt;
  assign ovrd_a[1]     = hawk_cpu_ovrd_wrpkt;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      hawk_req_gate_chan #(
        .ADDR_W    (ADDR_W),
        .ID_W      (ID_W),
        .PG_OFF_W  (PG_OFF_W),
        .TMO_W     (TMO_W),
        .HAS_WDATA (gi == 1)
      ) u_chan (
        .clk         (clk_i),
        .srst        (rst_i),
        .init_done   (init_done),
        .cpu_valid   (cpu_valid_a[gi]),
        .cpu_ready   (cpu_ready_a[gi]),
        .cpu_addr    (cpu_addr_a[gi]),
        .cpu_id      (cpu_id_a[gi]),
        .cpu_len     (cpu_len_a[gi]),
        .mem_valid   (mem_valid_a[gi]),
        .mem_ready   (mem_ready_a[gi]),
        .mem_addr    (mem_addr_a[gi]),
        .mem_id      (mem_id_a[gi]),
        .mem_len     (mem_len_a[gi]),
        .cpu_w_valid (cpu_w_valid),
        .cpu_w_ready (w_ready_a[gi]),
        .cpu_w_last  (cpu_w_last),
        .mem_w_valid (w_valid_a[gi]),
        .mem_w_ready (mem_w_ready),
        .reqpkt      (reqpkt_a[gi]),
        .ovrd        (ovrd_a[gi]),
        .tmo_err     (tmo_a[gi])
      );
    end
  endgenerate

  assign cpu_ar_ready  = cpu_ready_a[0];
  assign cpu_aw_ready  = cpu_ready_a[1];
  assign mem_ar_valid  = mem_valid_a[0];
  assign mem_aw_valid  = mem_valid_a[1];
  assign mem_ar_addr   = mem_addr_a[0];
  assign mem_aw_addr   = mem_addr_a[1];
  assign mem_ar_id     = mem_id_a[0];
  assign mem_aw_id     = mem_id_a[1];
  assign mem_ar_len    = mem_len_a[0];
  assign mem_aw_len    = mem_len_a[1];
  assign cpu_rd_reqpkt = reqpkt_a[0];
  assign cpu_wr_reqpkt = reqpkt_a[1];
  // The read instance ties its data-gate outputs low, so OR-ing is exact.
  assign cpu_w_ready   = |w_ready_a;
  assign mem_w_valid   = |w_valid_a;
  assign tmo_err       = tmo_a;

endmodule

// File: tb/tb_hawk_cpu_req_gate.sv
// Bench for hawk_cpu_req_gate: directed scenarios plus randomized read/write
// transactions compared against expectations computed from page arithmetic.
module tb_hawk_cpu_req_gate;
  import hacd_pkg::*;

  localparam int ADDR_W = 64;
  localparam int ID_W   = 5;
  localparam int TMO_W  = 10;
  localparam int TMO_MAX = (1 << TMO_W) - 1;
  localparam logic [63:0] OFF_MASK = (64'd1 << PG_OFF_W) - 64'd1;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic rst_i, init_done;
  logic cpu_ar_valid, cpu_ar_ready, cpu_aw_valid, cpu_aw_ready;
  logic [ADDR_W-1:0] cpu_ar_addr, cpu_aw_addr, mem_ar_addr, mem_aw_addr;
  logic [ID_W-1:0] cpu_ar_id, cpu_aw_id, mem_ar_id, mem_aw_id;
  logic [7:0] cpu_ar_len, cpu_aw_len, mem_ar_len, mem_aw_len;
  logic cpu_w_valid, cpu_w_ready, cpu_w_last;
  logic mem_ar_valid, mem_ar_ready, mem_aw_valid, mem_aw_ready;
  logic mem_w_valid, mem_w_ready;
  cpu_reqpkt_t cpu_rd_reqpkt, cpu_wr_reqpkt;
  hawk_cpu_ovrd_pkt_t hawk_cpu_ovrd_rdpkt, hawk_cpu_ovrd_wrpkt;
  logic [1:0] tmo_err;

  int checks = 0;
  int passes = 0;

  hawk_cpu_req_gate #(.ADDR_W(ADDR_W), .ID_W(ID_W), .PG_OFF_W(PG_OFF_W), .TMO_W(TMO_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .init_done(init_done),
    .cpu_ar_valid(cpu_ar_valid), .cpu_ar_ready(cpu_ar_ready), .cpu_ar_addr(cpu_ar_addr),
    .cpu_ar_id(cpu_ar_id), .cpu_ar_len(cpu_ar_len),
    .cpu_aw_valid(cpu_aw_valid), .cpu_aw_ready(cpu_aw_ready), .cpu_aw_addr(cpu_aw_addr),
    .cpu_aw_id(cpu_aw_id), .cpu_aw_len(cpu_aw_len),
    .cpu_w_valid(cpu_w_valid), .cpu_w_ready(cpu_w_ready), .cpu_w_last(cpu_w_last),
    .mem_ar_valid(mem_ar_valid), .mem_ar_ready(mem_ar_ready), .mem_ar_addr(mem_ar_addr),
    .mem_ar_id(mem_ar_id), .mem_ar_len(mem_ar_len),
    .mem_aw_valid(mem_aw_valid), .mem_aw_ready(mem_aw_ready), .mem_aw_addr(mem_aw_addr),
    .mem_aw_id(mem_aw_id), .mem_aw_len(mem_aw_len),
    .mem_w_valid(mem_w_valid), .mem_w_ready(mem_w_ready),
    .cpu_rd_reqpkt(cpu_rd_reqpkt), .cpu_wr_reqpkt(cpu_wr_reqpkt),
    .hawk_cpu_ovrd_rdpkt(hawk_cpu_ovrd_rdpkt), .hawk_cpu_ovrd_wrpkt(hawk_cpu_ovrd_wrpkt),
    .tmo_err(tmo_err)
  );

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_ar_valid = 0; cpu_ar_addr = '0; cpu_ar_id = '0; cpu_ar_len = '0;
    cpu_aw_valid = 0; cpu_aw_addr = '0; cpu_aw_id = '0; cpu_aw_len = '0;
    cpu_w_valid = 0; cpu_w_last = 0; mem_ar_ready = 0; mem_aw_ready = 0; mem_w_ready = 0;
    hawk_cpu_ovrd_rdpkt = '0; hawk_cpu_ovrd_wrpkt = '0;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Expected translated address: page number replaced, offset kept.
  function automatic logic [63:0] xlate(input logic [63:0] addr, input logic [51:0] ppa);
    return (64'(ppa) << PG_OFF_W) | (addr & OFF_MASK);
  endfunction

  task automatic rd_txn(input logic [63:0] addr, input logic [4:0] id, input logic [7:0] len,
                        input int gdly, input int stall, input logic [51:0] ppa);
    logic [63:0] exp_addr;
    exp_addr = xlate(addr, ppa);
    init_done = 1; cpu_ar_valid = 1; cpu_ar_addr = addr; cpu_ar_id = id; cpu_ar_len = len; #1;
    checks++; if (cpu_ar_ready !== 1'b1) $display("FAIL rd_accept_ready: got %b want 1", cpu_ar_ready); else passes++;
    cyc();
    cpu_ar_valid = 0; cpu_ar_addr = rnd64(); cpu_ar_id = 5'($urandom());
    for (int i = 0; i < gdly; i++) begin
      hawk_cpu_ovrd_rdpkt.ppa = 52'(rnd64()); init_done = 1'($urandom()); #1;
      checks++; if (cpu_rd_reqpkt.valid !== 1'b1 || cpu_rd_reqpkt.hppa !== 52'(addr >> PG_OFF_W))
        $display("FAIL rd_reqpkt: got v=%b hppa=%h want v=1 hppa=%h", cpu_rd_reqpkt.valid, cpu_rd_reqpkt.hppa, 52'(addr >> PG_OFF_W));
      else passes++;
      checks++; if (mem_ar_valid !== 1'b0 || cpu_ar_ready !== 1'b0)
        $display("FAIL rd_wait_quiet: got mem_v=%b rdy=%b want 0 0", mem_ar_valid, cpu_ar_ready);
      else passes++;
      cyc();
    end
    hawk_cpu_ovrd_rdpkt.allow_access = 1; hawk_cpu_ovrd_rdpkt.ppa = ppa; #1;
    checks++; if (cpu_rd_reqpkt.valid !== 1'b0) $display("FAIL rd_grant_drop: got %b want 0", cpu_rd_reqpkt.valid); else passes++;
    cyc();
    for (int i = 0; i <= stall; i++) begin
      mem_ar_ready = (i == stall);
      // Grants outside REQ must be ignored.
      hawk_cpu_ovrd_rdpkt.allow_access = (i < stall) ? 1'($urandom()) : 1'b0;
      hawk_cpu_ovrd_rdpkt.ppa = 52'(rnd64()); #1;
      checks++; if (mem_ar_valid !== 1'b1 || mem_ar_addr !== exp_addr || mem_ar_id !== id || mem_ar_len !== len)
        $display("FAIL rd_issue: got v=%b a=%h id=%0d len=%0d want 1 %h %0d %0d", mem_ar_valid, mem_ar_addr, mem_ar_id, mem_ar_len, exp_addr, id, len);
      else passes++;
      checks++; if (cpu_rd_reqpkt.valid !== 1'b0) $display("FAIL rd_issue_noreq: got %b want 0", cpu_rd_reqpkt.valid); else passes++;
      cyc();
    end
    mem_ar_ready = 0; hawk_cpu_ovrd_rdpkt = '0; #1;
    checks++; if (mem_ar_valid !== 1'b0 || cpu_ar_ready !== init_done)
      $display("FAIL rd_done: got mem_v=%b rdy=%b want 0 %b", mem_ar_valid, cpu_ar_ready, init_done);
    else passes++;
    $display("rd txn addr=%h id=%0d len=%0d ppa=%h -> mem_addr=%h", addr, id, len, ppa, exp_addr);
  endtask

  task automatic wr_txn(input logic [63:0] addr, input logic [4:0] id, input logic [7:0] len,
                        input int gdly, input int stall, input logic [51:0] ppa, input bit early_w);
    logic [63:0] exp_addr;
    int beats, guard;
    exp_addr = xlate(addr, ppa);
    init_done = 1; cpu_aw_valid = 1; cpu_aw_addr = addr; cpu_aw_id = id; cpu_aw_len = len;
    cpu_w_valid = early_w; mem_w_ready = 1; #1;
    checks++; if (cpu_aw_ready !== 1'b1) $display("FAIL wr_accept_ready: got %b want 1", cpu_aw_ready); else passes++;
    cyc();
    cpu_aw_valid = 0; cpu_aw_addr = rnd64();
    for (int i = 0; i < gdly; i++) begin
      cpu_w_last = 1'($urandom()); mem_w_ready = 1'($urandom()); #1;
      checks++; if (cpu_wr_reqpkt.valid !== 1'b1 || cpu_wr_reqpkt.hppa !== 52'(addr >> PG_OFF_W))
        $display("FAIL wr_reqpkt: got v=%b hppa=%h want v=1 hppa=%h", cpu_wr_reqpkt.valid, cpu_wr_reqpkt.hppa, 52'(addr >> PG_OFF_W));
      else passes++;
      checks++; if (cpu_w_ready !== 1'b0 || mem_w_valid !== 1'b0)
        $display("FAIL wr_early_w_req: got w_rdy=%b mem_w_v=%b want 0 0", cpu_w_ready, mem_w_valid);
      else passes++;
      cyc();
    end
    hawk_cpu_ovrd_wrpkt.allow_access = 1; hawk_cpu_ovrd_wrpkt.ppa = ppa; #1;
    checks++; if (cpu_wr_reqpkt.valid !== 1'b0) $display("FAIL wr_grant_drop: got %b want 0", cpu_wr_reqpkt.valid); else passes++;
    cyc();
    hawk_cpu_ovrd_wrpkt = '0;
    for (int i = 0; i <= stall; i++) begin
      mem_aw_ready = (i == stall); mem_w_ready = 1'($urandom()); #1;
      checks++; if (mem_aw_valid !== 1'b1 || mem_aw_addr !== exp_addr || mem_aw_id !== id || mem_aw_len !== len)
        $display("FAIL wr_issue: got v=%b a=%h id=%0d len=%0d want 1 %h %0d %0d", mem_aw_valid, mem_aw_addr, mem_aw_id, mem_aw_len, exp_addr, id, len);
      else passes++;
      checks++; if (cpu_w_ready !== 1'b0 || mem_w_valid !== 1'b0)
        $display("FAIL wr_early_w_issue: got w_rdy=%b mem_w_v=%b want 0 0", cpu_w_ready, mem_w_valid);
      else passes++;
      cyc();
    end
    mem_aw_ready = 0;
    beats = 0; guard = 0;
    while (beats <= int'(len) && guard < 300) begin
      cpu_w_valid = ($urandom_range(0, 3) != 0); mem_w_ready = ($urandom_range(0, 3) != 0);
      cpu_w_last = (beats == int'(len)); #1;
      checks++; if (mem_w_valid !== cpu_w_valid || cpu_w_ready !== mem_w_ready)
        $display("FAIL wr_data_pass: got mem_w_v=%b w_rdy=%b want %b %b", mem_w_valid, cpu_w_ready, cpu_w_valid, mem_w_ready);
      else passes++;
      if (cpu_w_valid && mem_w_ready) beats++;
      cyc(); guard++;
    end
    checks++; if (guard >= 300) $display("FAIL wr_data_bound: got beats=%0d want %0d", beats, int'(len) + 1); else passes++;
    cpu_w_valid = 1; mem_w_ready = 1; cpu_w_last = 0; #1;
    checks++; if (mem_w_valid !== 1'b0 || cpu_w_ready !== 1'b0 || cpu_aw_ready !== 1'b1)
      $display("FAIL wr_done: got mem_w_v=%b w_rdy=%b aw_rdy=%b want 0 0 1", mem_w_valid, cpu_w_ready, cpu_aw_ready);
    else passes++;
    cpu_w_valid = 0; mem_w_ready = 0;
    $display("wr txn addr=%h id=%0d len=%0d ppa=%h -> mem_addr=%h beats=%0d", addr, id, len, ppa, exp_addr, beats);
  endtask

  task automatic test_reset();
    idle_inputs(); rst_i = 1; init_done = 0;
    repeat (3) cyc();
    rst_i = 0; #1;
    checks++; if ({cpu_ar_ready, cpu_aw_ready, cpu_w_ready, mem_ar_valid, mem_aw_valid, mem_w_valid} !== 6'b0)
      $display("FAIL reset_ctrl: got %b want 000000", {cpu_ar_ready, cpu_aw_ready, cpu_w_ready, mem_ar_valid, mem_aw_valid, mem_w_valid});
    else passes++;
    checks++; if (cpu_rd_reqpkt !== '0 || cpu_wr_reqpkt !== '0 || tmo_err !== 2'b00 || mem_ar_addr !== '0 || mem_aw_addr !== '0)
      $display("FAIL reset_data: got rd=%h wr=%h tmo=%b want 0", cpu_rd_reqpkt, cpu_wr_reqpkt, tmo_err);
    else passes++;
  endtask

  task automatic test_init_gate();
    cyc();
    init_done = 0; cpu_ar_valid = 1; cpu_ar_addr = rnd64();
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if (cpu_ar_ready !== 1'b0 || cpu_rd_reqpkt.valid !== 1'b0)
        $display("FAIL init_block: got rdy=%b req_v=%b want 0 0", cpu_ar_ready, cpu_rd_reqpkt.valid);
      else passes++;
      cyc();
    end
    init_done = 1; #1;
    checks++; if (cpu_ar_ready !== 1'b1) $display("FAIL init_release: got %b want 1", cpu_ar_ready); else passes++;
    rd_txn(rnd64(), 5'd7, 8'd1, 2, 1, 52'(rnd64()));
  endtask

  task automatic test_basic_read();
    cyc();
    rd_txn(64'h0000_0000_8000_1A3C, 5'd3, 8'd0, 4, 4, 52'h00042);
    checks++; if (xlate(64'h0000_0000_8000_1A3C, 52'h00042) !== mem_ar_addr)
      $display("FAIL rd_addr_held: got %h want %h", mem_ar_addr, 64'h42A3C);
    else passes++;
  endtask

  task automatic test_early_wdata();
    cyc();
    wr_txn(64'h2000, 5'd9, 8'd3, 3, 2, 52'h00123, 1'b1);
  endtask

  task automatic test_back_to_back_dual();
    logic [63:0] ra, wa;
    logic [51:0] rp, wp;
    ra = rnd64(); wa = rnd64(); rp = 52'(rnd64()); wp = 52'(rnd64());
    cyc();
    init_done = 1; cpu_ar_valid = 1; cpu_ar_addr = ra; cpu_ar_id = 5'd1;
    cpu_aw_valid = 1; cpu_aw_addr = wa; cpu_aw_id = 5'd2; #1;
    checks++; if (cpu_ar_ready !== 1'b1 || cpu_aw_ready !== 1'b1)
      $display("FAIL dual_accept: got ar=%b aw=%b want 1 1", cpu_ar_ready, cpu_aw_ready);
    else passes++;
    cyc();
    cpu_ar_valid = 0; cpu_aw_valid = 0; #1;
    checks++; if (cpu_rd_reqpkt.valid !== 1'b1 || cpu_wr_reqpkt.valid !== 1'b1 ||
                  cpu_rd_reqpkt.hppa !== 52'(ra >> PG_OFF_W) || cpu_wr_reqpkt.hppa !== 52'(wa >> PG_OFF_W))
      $display("FAIL dual_req: got rd=%h wr=%h", cpu_rd_reqpkt, cpu_wr_reqpkt);
    else passes++;
    cyc();
    hawk_cpu_ovrd_wrpkt.allow_access = 1; hawk_cpu_ovrd_wrpkt.ppa = wp; #1;
    checks++; if (cpu_wr_reqpkt.valid !== 1'b0 || cpu_rd_reqpkt.valid !== 1'b1)
      $display("FAIL dual_wgrant: got wr_v=%b rd_v=%b want 0 1", cpu_wr_reqpkt.valid, cpu_rd_reqpkt.valid);
    else passes++;
    cyc();
    hawk_cpu_ovrd_wrpkt = '0; mem_aw_ready = 1; #1;
    checks++; if (mem_aw_valid !== 1'b1 || mem_aw_addr !== xlate(wa, wp) || mem_ar_valid !== 1'b0 || cpu_rd_reqpkt.valid !== 1'b1)
      $display("FAIL dual_aw_issue: got aw_v=%b aw=%h ar_v=%b want 1 %h 0", mem_aw_valid, mem_aw_addr, mem_ar_valid, xlate(wa, wp));
    else passes++;
    cyc();
    mem_aw_ready = 0; cpu_w_valid = 1; cpu_w_last = 1; mem_w_ready = 1; #1;
    checks++; if (mem_w_valid !== 1'b1) $display("FAIL dual_wbeat: got %b want 1", mem_w_valid); else passes++;
    cyc();
    cpu_w_valid = 0; cpu_w_last = 0; mem_w_ready = 0;
    hawk_cpu_ovrd_rdpkt.allow_access = 1; hawk_cpu_ovrd_rdpkt.ppa = rp; #1;
    checks++; if (cpu_rd_reqpkt.valid !== 1'b0 || cpu_aw_ready !== 1'b1)
      $display("FAIL dual_rgrant: got rd_v=%b aw_rdy=%b want 0 1", cpu_rd_reqpkt.valid, cpu_aw_ready);
    else passes++;
    cyc();
    hawk_cpu_ovrd_rdpkt = '0; mem_ar_ready = 1; #1;
    checks++; if (mem_ar_valid !== 1'b1 || mem_ar_addr !== xlate(ra, rp) || mem_ar_id !== 5'd1)
      $display("FAIL dual_ar_issue: got v=%b a=%h id=%0d want 1 %h 1", mem_ar_valid, mem_ar_addr, mem_ar_id, xlate(ra, rp));
    else passes++;
    cyc();
    mem_ar_ready = 0; #1;
    checks++; if (mem_ar_valid !== 1'b0 || cpu_ar_ready !== 1'b1)
      $display("FAIL dual_done: got v=%b rdy=%b want 0 1", mem_ar_valid, cpu_ar_ready);
    else passes++;
    $display("dual txn rd=%h->%h wr=%h->%h", ra, xlate(ra, rp), wa, xlate(wa, wp));
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      cyc();
      if ($urandom_range(0, 1) == 0)
        rd_txn(rnd64(), 5'($urandom()), 8'($urandom()), $urandom_range(0, 5), $urandom_range(0, 4), 52'(rnd64()));
      else
        wr_txn(rnd64(), 5'($urandom()), 8'($urandom_range(0, 7)), $urandom_range(0, 5), $urandom_range(0, 4), 52'(rnd64()), 1'($urandom()));
    end
  endtask

  task automatic test_rst_in_data();
    cyc();
    init_done = 1; cpu_aw_valid = 1; cpu_aw_addr = rnd64(); cpu_aw_len = 8'd3;
    cyc();
    cpu_aw_valid = 0; hawk_cpu_ovrd_wrpkt.allow_access = 1; hawk_cpu_ovrd_wrpkt.ppa = 52'h5;
    cyc();
    hawk_cpu_ovrd_wrpkt = '0; mem_aw_ready = 1;
    cyc();
    mem_aw_ready = 0; cpu_w_valid = 1; mem_w_ready = 1; cpu_w_last = 0; #1;
    checks++; if (mem_w_valid !== 1'b1) $display("FAIL rst_data_pre: got %b want 1", mem_w_valid); else passes++;
    cyc();
    rst_i = 1; #1;
    checks++; if (mem_w_valid !== 1'b0 || cpu_w_ready !== 1'b0)
      $display("FAIL rst_data_during: got mem_w_v=%b w_rdy=%b want 0 0", mem_w_valid, cpu_w_ready);
    else passes++;
    cyc();
    rst_i = 0; #1;
    checks++; if (mem_w_valid !== 1'b0 || cpu_w_ready !== 1'b0 || cpu_aw_ready !== init_done ||
                  cpu_wr_reqpkt.valid !== 1'b0 || mem_aw_valid !== 1'b0)
      $display("FAIL rst_data_after: got mem_w_v=%b w_rdy=%b aw_rdy=%b want 0 0 1", mem_w_valid, cpu_w_ready, cpu_aw_ready);
    else passes++;
    idle_inputs();
    wr_txn(rnd64(), 5'd4, 8'd2, 1, 0, 52'(rnd64()), 1'b0);
  endtask

  task automatic test_timeout();
    logic [63:0] a;
    logic [51:0] p;
    a = rnd64(); p = 52'(rnd64());
    cyc();
    init_done = 1; cpu_ar_valid = 1; cpu_ar_addr = a; cpu_ar_id = 5'd5;
    cyc();
    cpu_ar_valid = 0; #1;
    checks++; if (tmo_err !== 2'b00 || cpu_rd_reqpkt.valid !== 1'b1)
      $display("FAIL tmo_start: got tmo=%b v=%b want 00 1", tmo_err, cpu_rd_reqpkt.valid);
    else passes++;
    for (int k = 1; k < TMO_MAX; k++) cyc();
    #1;
    checks++; if (tmo_err !== 2'b00) $display("FAIL tmo_early: got %b want 00", tmo_err); else passes++;
    cyc(); #1;
    checks++; if (tmo_err !== 2'b01) $display("FAIL tmo_set: got %b want 01", tmo_err); else passes++;
    repeat (5) cyc();
    #1;
    checks++; if (tmo_err !== 2'b01 || cpu_rd_reqpkt.valid !== 1'b1)
      $display("FAIL tmo_wait: got tmo=%b v=%b want 01 1", tmo_err, cpu_rd_reqpkt.valid);
    else passes++;
    cyc();
    hawk_cpu_ovrd_rdpkt.allow_access = 1; hawk_cpu_ovrd_rdpkt.ppa = p;
    cyc();
    hawk_cpu_ovrd_rdpkt = '0; mem_ar_ready = 1; #1;
    checks++; if (mem_ar_valid !== 1'b1 || mem_ar_addr !== xlate(a, p) || tmo_err !== 2'b01)
      $display("FAIL tmo_issue: got v=%b a=%h tmo=%b want 1 %h 01", mem_ar_valid, mem_ar_addr, tmo_err, xlate(a, p));
    else passes++;
    cyc();
    mem_ar_ready = 0; #1;
    checks++; if (tmo_err !== 2'b01) $display("FAIL tmo_sticky: got %b want 01", tmo_err); else passes++;
    cyc();
    rst_i = 1; #1;
    checks++; if (cpu_ar_ready !== 1'b0) $display("FAIL tmo_rst_ready: got %b want 0", cpu_ar_ready); else passes++;
    cyc();
    rst_i = 0; #1;
    checks++; if (tmo_err !== 2'b00 || cpu_rd_reqpkt !== '0 || mem_ar_addr !== '0 || mem_ar_valid !== 1'b0)
      $display("FAIL tmo_rst_clear: got tmo=%b req=%h a=%h want 0", tmo_err, cpu_rd_reqpkt, mem_ar_addr);
    else passes++;
    $display("timeout txn addr=%h held %0d cycles before grant", a, TMO_MAX + 7);
  endtask

  initial begin
    rst_i = 1; init_done = 0;
    idle_inputs();
    test_reset();
    test_init_gate();
    test_basic_read();
    test_early_wdata();
    test_back_to_back_dual();
    test_random();
    test_rst_in_data();
    test_timeout();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
